// File: rtl/map_fetch_pkg.sv
// map_fetch_pkg: chunk codes shared with the renderer and the map geometry
// shared with game logic.
package map_fetch_pkg;

  localparam int MAP_W      = 10;  // map width in tiles
  localparam int MAP_H      = 8;   // map height in tiles
  localparam int TILE_SHIFT = 5;   // 32 px tiles
  localparam int CHUNK_W    = 4;

  typedef enum logic [CHUNK_W-1:0] {
    PLAYER_UP    = 4'd0,
    PLAYER_DOWN  = 4'd1,
    PLAYER_LEFT  = 4'd2,
    PLAYER_RIGHT = 4'd3,
    BOX          = 4'd4,
    TARGET       = 4'd5,
    WALL         = 4'd6,
    GROUND       = 4'd7,
    SIDE         = 4'd8
  } chunk_e;

  // Codes that may legitimately come out of the level RAM; anything else
  // (player codes, SIDE, unassigned values) is drawn as ground.
  function automatic logic is_map_tile(input logic [CHUNK_W-1:0] code);
    return (code >= BOX) && (code <= GROUND);
  endfunction

endpackage

// File: rtl/map_fetch_if.sv
// map_fetch_if: pixel stream in, map RAM read port, chunk stream out.
// The slave modport is the map_fetch view; master is the driving side.
interface map_fetch_if
  import map_fetch_pkg::*;
#(
  parameter int ADDR_W = 7
);
  logic [9:0]         pix_x;
  logic [8:0]         pix_y;
  logic               pix_valid;
  logic               hs_in;
  logic               vs_in;
  logic [3:0]         player_x;
  logic [2:0]         player_y;
  logic [1:0]         player_dir;
  logic [ADDR_W-1:0]  map_addr;
  logic [CHUNK_W-1:0] map_data;
  logic [CHUNK_W-1:0] chunk_type;
  logic               chunk_valid;
  logic               hs_out;
  logic               vs_out;

  modport slave (
    input  pix_x, pix_y, pix_valid, hs_in, vs_in,
    input  player_x, player_y, player_dir, map_data,
    output map_addr, chunk_type, chunk_valid, hs_out, vs_out
  );

  modport master (
    output pix_x, pix_y, pix_valid, hs_in, vs_in,
    output player_x, player_y, player_dir, map_data,
    input  map_addr, chunk_type, chunk_valid, hs_out, vs_out
  );
endinterface

// File: rtl/map_fetch_sync_delay.sv
// map_fetch_sync_delay: fixed-depth shift register carrying the video
// control signals alongside the data pipeline. Reset loads RST_VAL into
// every stage so no stale sync survives a reset.
module map_fetch_sync_delay
  import map_fetch_pkg::*;
#(
  parameter int                DATA_W  = 3,
  parameter int                STAGES  = 2,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] pipe_q [STAGES];

  // Shift one stage per clock; stage 0 takes the live input.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < STAGES; i++) pipe_q[i] <= RST_VAL;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[STAGES-1];

endmodule

// File: rtl/map_fetch.sv
// map_fetch: turns the VGA pixel coordinate stream into one chunk code per
// pixel, reading the level map RAM and overlaying the player sprite.
// Latency is 2 clocks; sync/valid are delayed to match.
// Optional build macro MAP_FETCH_PLAYER_BLINK_EN: frame counter that hides
// the player on alternate 16-frame periods.
module map_fetch
  import map_fetch_pkg::*;
#(
  parameter int MAP_W      = map_fetch_pkg::MAP_W,
  parameter int MAP_H      = map_fetch_pkg::MAP_H,
  parameter int TILE_SHIFT = map_fetch_pkg::TILE_SHIFT,
  parameter int X0         = 160,
  parameter int Y0         = 112,
  parameter int ADDR_W     = 7
`ifdef MAP_FETCH_PLAYER_BLINK_EN
  ,
  parameter int BLINK_SHIFT = 4
`endif
) (
  input  logic        clk,
  input  logic        rstn,
  map_fetch_if.slave  bus
);

  localparam logic signed [10:0] X0_S    = 11'(X0);
  localparam logic signed [9:0]  Y0_S    = 10'(Y0);
  localparam logic signed [10:0] XSPAN_S = 11'(MAP_W << TILE_SHIFT);
  localparam logic signed [9:0]  YSPAN_S = 10'(MAP_H << TILE_SHIFT);

  // Final code selection, applied to the RAM word in stage 1.
  function automatic chunk_e select_code(input logic               in_map,
                                         input logic               hit,
                                         input logic [1:0]         dir,
                                         input logic [CHUNK_W-1:0] code);
    if (!in_map)          return SIDE;
    if (hit)              return chunk_e'({2'b00, dir});
    if (is_map_tile(code)) return chunk_e'(code);
    return GROUND;
  endfunction

  // Player position latched once per frame
  logic [3:0]        px_l_q, px_l_d;
  logic [2:0]        py_l_q, py_l_d;
  logic [1:0]        dir_l_q, dir_l_d;
  logic              vs_prev_q;
  logic              vs_fall;
  logic              show_player;

  // Stage 0 signals and stage 0 -> 1 registers
  logic signed [10:0] dx_p0;
  logic signed [9:0]  dy_p0;
  logic               in_map_p0;
  logic [3:0]         tx_p0;
  logic [2:0]         ty_p0;
  logic [ADDR_W-1:0]  addr_p0;
  logic               player_ok;
  logic               hit_p0;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               in_map_p1_q;
  logic               hit_p1_q;
  logic [1:0]         dir_p1_q;

  // Stage 1 -> 2 register
  chunk_e             chunk_p1_d;
  chunk_e             chunk_p2_q;

  assign vs_fall = vs_prev_q & ~bus.vs_in;

  // Load the player registers only at the start of vertical sync so a
  // mid-frame update from game logic never tears the image.
  always_comb begin
    px_l_d  = px_l_q;
    py_l_d  = py_l_q;
    dir_l_d = dir_l_q;
    if (vs_fall) begin
      px_l_d  = bus.player_x;
      py_l_d  = bus.player_y;
      dir_l_d = bus.player_dir;
    end
  end

  // Player latch and vsync edge detector.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      px_l_q    <= '0;
      py_l_q    <= '0;
      dir_l_q   <= '0;
      vs_prev_q <= 1'b1;
    end else begin
      px_l_q    <= px_l_d;
      py_l_q    <= py_l_d;
      dir_l_q   <= dir_l_d;
      vs_prev_q <= bus.vs_in;
    end
  end

`ifdef MAP_FETCH_PLAYER_BLINK_EN
  logic [7:0] frame_q, frame_d;

  // Frame counter advances on every vsync falling edge.
  always_comb begin
    frame_d = frame_q;
    if (vs_fall) frame_d = frame_q + 8'd1;
  end

  // Frame counter register.
  always_ff @(posedge clk) begin
    if (!rstn) frame_q <= '0;
    else       frame_q <= frame_d;
  end

  assign show_player = ~frame_q[BLINK_SHIFT];
`else
  assign show_player = 1'b1;
`endif

  // ---- Stage 0: coordinate -> tile, RAM address, player hit ----
  assign dx_p0 = $signed({1'b0, bus.pix_x}) - X0_S;
  assign dy_p0 = $signed({1'b0, bus.pix_y}) - Y0_S;

  assign in_map_p0 = bus.pix_valid
                   && (dx_p0 >= 11'sd0) && (dx_p0 < XSPAN_S)
                   && (dy_p0 >= 10'sd0) && (dy_p0 < YSPAN_S);

  assign tx_p0   = 4'($unsigned(dx_p0) >> TILE_SHIFT);
  assign ty_p0   = 3'($unsigned(dy_p0) >> TILE_SHIFT);
  assign addr_p0 = ADDR_W'(32'(ty_p0) * MAP_W + 32'(tx_p0));

  // An off-map player position can never match a tile.
  assign player_ok = (32'(px_l_q) < MAP_W) && (32'(py_l_q) < MAP_H);
  assign hit_p0    = show_player && player_ok
                   && (tx_p0 == px_l_q) && (ty_p0 == py_l_q);

  // The address register doubles as the RAM's address stage; it holds
  // outside the map so the RAM is not exercised needlessly.
  always_comb begin
    addr_d = addr_q;
    if (in_map_p0) addr_d = addr_p0;
  end

  // Stage 0 -> 1 registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      addr_q      <= '0;
      in_map_p1_q <= 1'b0;
      hit_p1_q    <= 1'b0;
      dir_p1_q    <= '0;
    end else begin
      addr_q      <= addr_d;
      in_map_p1_q <= in_map_p0;
      hit_p1_q    <= hit_p0;
      dir_p1_q    <= dir_l_q;
    end
  end

  assign bus.map_addr = addr_q;

  // ---- Stage 1: RAM word available, pick the chunk code ----
  assign chunk_p1_d = select_code(in_map_p1_q, hit_p1_q, dir_p1_q, bus.map_data);

  // Stage 1 -> 2 output register.
  always_ff @(posedge clk) begin
    if (!rstn) chunk_p2_q <= SIDE;
    else       chunk_p2_q <= chunk_p1_d;
  end

  assign bus.chunk_type = chunk_p2_q;

  // ---- Control delay line: valid, hsync, vsync ----
  logic [2:0] sync_p2;

  map_fetch_sync_delay #(
    .DATA_W  (3),
    .STAGES  (2),
    .RST_VAL (3'b011)
  ) u_sync_delay (
    .clk  (clk),
    .rstn (rstn),
    .d_i  ({bus.pix_valid, bus.hs_in, bus.vs_in}),
    .q_o  (sync_p2)
  );

  assign {bus.chunk_valid, bus.hs_out, bus.vs_out} = sync_p2;

endmodule
